// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM transmit chain: sample width, default symbol
// geometry and the cyclic-prefix read-state encoding.
package ofdm_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int DEF_FFT_SIZE = 1024;
    localparam int DEF_CP_LEN   = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } rd_state_e;

endpackage

// File: rtl/cp_inserter_if.sv
// AXI-Stream input and output links of the cyclic-prefix inserter.
// The slave view belongs to the inserter; the master view drives it.
interface cp_inserter_if;
    import ofdm_pkg::*;

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tlast;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tlast;

    modport slave (
        input  s_valid, s_tdata, s_tlast, m_ready,
        output s_ready, m_valid, m_tdata, m_tlast
    );

    modport master (
        output s_valid, s_tdata, s_tlast, m_ready,
        input  s_ready, m_valid, m_tdata, m_tlast
    );

endinterface

// File: rtl/axis_skid2.sv
// Two-entry output buffer. The producer only pushes when it holds a credit,
// so there is no upstream ready; the occupancy is exported for credit counting.
module axis_skid2 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic [1:0]    count_o
);

    logic [DW:0] ent_q [2];
    logic        head_q;
    logic        tail_q;
    logic [1:0]  count_q;
    logic        push;
    logic        pop;

    assign push = in_valid_i;
    assign pop  = out_valid_o && out_ready_i;

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) tail_q <= ~tail_q;
            if (pop)  head_q <= ~head_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    // NOTE: payload storage carries no reset; validity lives in count_q, so clearing control state is enough.
    always_ff @(posedge clk) begin
        if (push) ent_q[tail_q] <= {in_last_i, in_data_i};
    end

    assign out_valid_o               = (count_q != 2'd0);
    assign {out_last_o, out_data_o}  = out_valid_o ? ent_q[head_q] : '0;
    assign count_o                   = count_q;

endmodule

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: ping-pong symbol buffer written from the input stream,
// read back as the last CP_LEN samples followed by the whole symbol.
module cp_inserter
    import ofdm_pkg::*;
#(
    parameter int FFT_SIZE  = DEF_FFT_SIZE,
    parameter int CP_LEN    = DEF_CP_LEN,
    parameter int ADDR_BITS = $clog2(FFT_SIZE)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         reset_mod,
    cp_inserter_if.slave bus,
    output logic [1:0]   st,
    output logic         frame_err
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(FFT_SIZE - 1);
    localparam logic [ADDR_BITS-1:0] FIRST_IDX = (CP_LEN == 0) ? '0 : ADDR_BITS'(FFT_SIZE - CP_LEN);
    localparam rd_state_e            FIRST_ST  = (CP_LEN == 0) ? ST_BODY : ST_CP;

    logic clr;
    assign clr = !rst || reset_mod;

    logic [DATA_WIDTH-1:0] mem [2*FFT_SIZE];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;

    logic [1:0]           full_q,      full_d;
    logic                 wbank_q,     wbank_d;
    logic [ADDR_BITS-1:0] wr_idx_q,    wr_idx_d;
    logic                 frame_err_q, frame_err_d;
    rd_state_e            state_q,     state_d;
    logic                 rbank_q,     rbank_d;
    logic [ADDR_BITS-1:0] rd_idx_q,    rd_idx_d;

    logic       wr_en, wr_close;
    logic       rd_en, rd_last, rd_close;
    logic       pop, credit_ok;
    logic [1:0] skid_count;
    logic [2:0] pending;

    assign bus.s_ready = !full_q[wbank_q];
    assign wr_en       = bus.s_valid && bus.s_ready && !clr;

    always_comb begin
        // NOTE: every output gets a default first, so no path holds a stale value and no latch is inferred.
        wbank_d     = wbank_q;
        wr_idx_d    = wr_idx_q;
        frame_err_d = frame_err_q;
        wr_close    = 1'b0;
        if (wr_en) begin
            if (wr_idx_q == LAST_IDX) begin
                wr_close = 1'b1;
                wbank_d  = ~wbank_q;
                wr_idx_d = '0;
                if (!bus.s_tlast) frame_err_d = 1'b1;
            end else if (bus.s_tlast) begin
                frame_err_d = 1'b1;
                wr_idx_d    = '0;
            end else begin
                wr_idx_d = wr_idx_q + ADDR_BITS'(1);
            end
        end
    end

    // Issue only if the skid can absorb this read on top of what is already in flight.
    assign pop       = bus.m_valid && bus.m_ready;
    assign pending   = {1'b0, skid_count} + {2'b0, rd_valid_q};
    assign credit_ok = (pending < 3'd2) || ((pending == 3'd2) && pop);

    always_comb begin
        state_d  = state_q;
        rbank_d  = rbank_q;
        rd_idx_d = rd_idx_q;
        rd_en    = 1'b0;
        rd_last  = 1'b0;
        rd_close = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rbank_q]) begin
                    state_d  = FIRST_ST;
                    rd_idx_d = FIRST_IDX;
                end
            end
            ST_CP: begin
                rd_en = credit_ok;
                if (rd_en) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = ST_BODY;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + ADDR_BITS'(1);
                    end
                end
            end
            ST_BODY: begin
                rd_en = credit_ok;
                if (rd_en) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_last  = 1'b1;
                        rd_close = 1'b1;
                        rbank_d  = ~rbank_q;
                        if (full_q[~rbank_q]) begin
                            state_d  = FIRST_ST;
                            rd_idx_d = FIRST_IDX;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + ADDR_BITS'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Writer and reader never own the same bank, so both updates can land together.
    always_comb begin
        full_d = full_q;
        if (wr_close) full_d[wbank_q] = 1'b1;
        if (rd_close) full_d[rbank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            full_q      <= 2'b00;
            wbank_q     <= 1'b0;
            wr_idx_q    <= '0;
            frame_err_q <= 1'b0;
            state_q     <= ST_IDLE;
            rbank_q     <= 1'b0;
            rd_idx_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            full_q      <= full_d;
            wbank_q     <= wbank_d;
            wr_idx_q    <= wr_idx_d;
            frame_err_q <= frame_err_d;
            state_q     <= state_d;
            rbank_q     <= rbank_d;
            rd_idx_q    <= rd_idx_d;
            rd_valid_q  <= rd_en;
            rd_last_q   <= rd_last;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wbank_q, wr_idx_q}] <= bus.s_tdata;
        if (rd_en) rdata_q <= mem[{rbank_q, rd_idx_q}];
    end

    axis_skid2 #(
        .DW (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (!clr),
        .in_valid_i  (rd_valid_q),
        .in_data_i   (rdata_q),
        .in_last_i   (rd_last_q),
        .out_valid_o (bus.m_valid),
        .out_ready_i (bus.m_ready),
        .out_data_o  (bus.m_tdata),
        .out_last_o  (bus.m_tlast),
        .count_o     (skid_count)
    );

    assign st        = state_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cp_inserter.sv
// Self-checking bench for cp_inserter: a symbol-level model predicts every output
// beat and the framing-error flag; directed checks pin the model with literals.
module tb_cp_inserter;
    import ofdm_pkg::*;

    localparam int FFT = 1024;
    localparam int CP  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       reset_mod_a;
    logic       reset_mod_b;
    logic [1:0] st_a, st_b;
    logic       fe_a, fe_b;

    cp_inserter_if bus_a ();
    cp_inserter_if bus_b ();

    cp_inserter #(.FFT_SIZE(FFT), .CP_LEN(CP)) dut_a (
        .clk(clk), .rst(rst), .reset_mod(reset_mod_a), .bus(bus_a), .st(st_a), .frame_err(fe_a)
    );

    cp_inserter #(.FFT_SIZE(FFT), .CP_LEN(0)) dut_b (
        .clk(clk), .rst(rst), .reset_mod(reset_mod_b), .bus(bus_b), .st(st_b), .frame_err(fe_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model of dut_a ----------------
    typedef struct packed { logic [31:0] d; logic l; } exp_t;
    typedef struct { logic [31:0] d; logic l; int c; } beat_t;

    exp_t        exp_q [$];
    logic [31:0] part  [$];
    beat_t       log_a [$];
    bit          err_m     = 1'b0;
    bit          stalled   = 1'b0;
    logic [32:0] held      = '0;
    int          close_cyc = -1;

    always @(negedge clk) begin
        check("frame_err", 64'(fe_a), 64'(err_m));
        if (stalled) begin
            check("hold_valid", 64'(bus_a.m_valid), 64'd1);
            check("hold_data", 64'({bus_a.m_tlast, bus_a.m_tdata}), 64'(held));
        end
        if (!rst || reset_mod_a) begin
            exp_q.delete();
            part.delete();
            err_m   = 1'b0;
            stalled = 1'b0;
        end else begin
            if (bus_a.m_valid && bus_a.m_ready) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("m_tdata", 64'(bus_a.m_tdata), 64'(e.d));
                    check("m_tlast", 64'(bus_a.m_tlast), 64'(e.l));
                end
                log_a.push_back('{bus_a.m_tdata, bus_a.m_tlast, cyc});
            end
            stalled = bus_a.m_valid && !bus_a.m_ready;
            held    = {bus_a.m_tlast, bus_a.m_tdata};
            if (bus_a.s_valid && bus_a.s_ready) begin
                part.push_back(bus_a.s_tdata);
                if (part.size() == FFT) begin
                    if (!bus_a.s_tlast) err_m = 1'b1;
                    for (int i = FFT - CP; i < FFT; i++) exp_q.push_back('{part[i], 1'b0});
                    for (int i = 0; i < FFT; i++) exp_q.push_back('{part[i], (i == FFT - 1)});
                    part.delete();
                    close_cyc = cyc;
                end else if (bus_a.s_tlast) begin
                    err_m = 1'b1;
                    part.delete();
                end
            end
        end
    end

    bit   rnd_ready   = 1'b0;
    logic ready_level = 1'b1;

    always @(posedge clk) begin
        #1;
        bus_a.m_ready = rnd_ready ? 1'($urandom_range(1, 0)) : ready_level;
    end

    // ---------------- monitor of dut_b ----------------
    logic [32:0] log_b [$];
    bit          st1_seen = 1'b0;

    always @(negedge clk) begin
        if (bus_b.m_valid && bus_b.m_ready) log_b.push_back({bus_b.m_tlast, bus_b.m_tdata});
        if (st_b == 2'd1) st1_seen = 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_a(input int n, input bit seq, input bit rnd_v, output int stalls);
        int guard;
        bit hs;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (rnd_v && $urandom_range(3, 0) == 0) begin
                bus_a.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus_a.s_valid = 1'b1;
            bus_a.s_tdata = seq ? 32'(i) : $urandom();
            bus_a.s_tlast = (i == n - 1);
            guard = 0;
            do begin
                hs = bus_a.s_ready;
                @(posedge clk); #1;
                if (!hs) begin
                    stalls++;
                    guard++;
                end
            end while (!hs && guard < 20000);
            if (!hs) begin
                check("send_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        bus_a.s_valid = 1'b0;
        bus_a.s_tlast = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || bus_a.m_valid || st_a != 2'd0) && g < 30000) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_timeout", 64'(g >= 30000), 64'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    function automatic int count_lasts(input int from);
        int n = 0;
        for (int i = from; i < log_a.size(); i++) if (log_a[i].l) n++;
        return n;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int base, n0, s1, s2, s3, s4, g, bad, lasts;

        rst = 1'b0; reset_mod_a = 1'b0; reset_mod_b = 1'b0;
        bus_a.s_valid = 1'b0; bus_a.s_tdata = '0; bus_a.s_tlast = 1'b0;
        bus_b.s_valid = 1'b0; bus_b.s_tdata = '0; bus_b.s_tlast = 1'b0; bus_b.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        check("rst_s_ready",   64'(bus_a.s_ready), 64'd1);
        check("rst_m_valid",   64'(bus_a.m_valid), 64'd0);
        check("rst_m_tdata",   64'(bus_a.m_tdata), 64'd0);
        check("rst_m_tlast",   64'(bus_a.m_tlast), 64'd0);
        check("rst_st",        64'(st_a),          64'd0);
        check("rst_frame_err", 64'(fe_a),          64'd0);

        // single ramp symbol, full-rate output
        base = log_a.size();
        send_a(FFT, 1'b1, 1'b0, s1);
        wait_drain();
        check("t1_beats", 64'(log_a.size() - base), 64'd1280);
        if (log_a.size() - base == 1280) begin
            check("t1_first_cp",  64'(log_a[base].d),        64'd768);
            check("t1_last_cp",   64'(log_a[base + 255].d),  64'd1023);
            check("t1_body0",     64'(log_a[base + 256].d),  64'd0);
            check("t1_final",     64'(log_a[base + 1279].d), 64'd1023);
            check("t1_final_tl",  64'(log_a[base + 1279].l), 64'd1);
            check("t1_latency",   64'(log_a[base].c - close_cyc), 64'd4);
        end
        check("t1_tlast_count", 64'(count_lasts(base)), 64'd1);
        check("t1_frame_err",   64'(fe_a), 64'd0);

        // four back-to-back symbols
        base = log_a.size();
        send_a(FFT, 1'b0, 1'b0, s1);
        send_a(FFT, 1'b0, 1'b0, s2);
        send_a(FFT, 1'b0, 1'b0, s3);
        send_a(FFT, 1'b0, 1'b0, s4);
        wait_drain();
        check("t2_beats", 64'(log_a.size() - base), 64'd5120);
        if (log_a.size() - base == 5120)
            check("t2_contiguous", 64'(log_a[base + 5119].c - log_a[base].c), 64'd5119);
        check("t2_no_stall_free_banks", 64'(s1 + s2), 64'd0);
        check("t2_stall_both_full",     64'(s3 > 0), 64'd1);
        check("t2_tlast_count",         64'(count_lasts(base)), 64'd4);

        // random backpressure and input gaps
        rnd_ready = 1'b1;
        base = log_a.size();
        send_a(FFT, 1'b0, 1'b1, s1);
        send_a(FFT, 1'b0, 1'b1, s2);
        wait_drain();
        rnd_ready = 1'b0;
        check("t3_beats",       64'(log_a.size() - base), 64'd2560);
        check("t3_tlast_count", 64'(count_lasts(base)), 64'd2);

        // early tlast after 500 samples, then a clean symbol
        base = log_a.size();
        send_a(500, 1'b1, 1'b0, s1);
        send_a(FFT, 1'b0, 1'b0, s2);
        wait_drain();
        check("t4_frame_err",   64'(fe_a), 64'd1);
        check("t4_beats",       64'(log_a.size() - base), 64'd1280);
        check("t4_tlast_count", 64'(count_lasts(base)), 64'd1);

        // soft reset mid-frame with a second symbol buffered
        ready_level = 1'b0;
        base = log_a.size();
        send_a(FFT, 1'b0, 1'b0, s1);
        send_a(FFT, 1'b0, 1'b0, s2);
        check("t5_s_ready_both_full", 64'(bus_a.s_ready), 64'd0);
        ready_level = 1'b1;
        g = 0;
        while (log_a.size() - base < 600 && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        check("t5_reach_600_timeout", 64'(g >= 5000), 64'd0);
        reset_mod_a = 1'b1;
        @(posedge clk); #1;
        reset_mod_a = 1'b0;
        check("t5_m_valid", 64'(bus_a.m_valid), 64'd0);
        check("t5_st",      64'(st_a), 64'd0);
        check("t5_fe_clr",  64'(fe_a), 64'd0);
        check("t5_s_ready", 64'(bus_a.s_ready), 64'd1);
        n0 = log_a.size();
        repeat (200) @(posedge clk);
        #1;
        check("t5_silent",  64'(log_a.size() - n0), 64'd0);
        check("t5_st_idle", 64'(st_a), 64'd0);
        send_a(FFT, 1'b1, 1'b0, s1);
        wait_drain();
        check("t5_new_beats", 64'(log_a.size() - n0), 64'd1280);
        if (log_a.size() - n0 == 1280)
            check("t5_new_first", 64'(log_a[n0].d), 64'd768);

        // CP_LEN = 0 instance, ramp symbol
        for (int i = 0; i < FFT; i++) begin
            bit hs;
            g = 0;
            bus_b.s_valid = 1'b1;
            bus_b.s_tdata = 32'(i);
            bus_b.s_tlast = (i == FFT - 1);
            do begin
                hs = bus_b.s_ready;
                @(posedge clk); #1;
                g++;
            end while (!hs && g < 100);
        end
        bus_b.s_valid = 1'b0;
        bus_b.s_tlast = 1'b0;
        g = 0;
        while (log_b.size() < FFT && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("t6_beats", 64'(log_b.size()), 64'(FFT));
        bad   = 0;
        lasts = 0;
        for (int i = 0; i < log_b.size(); i++) begin
            if (log_b[i][31:0] != 32'(i)) bad++;
            if (log_b[i][32]) lasts++;
        end
        check("t6_data_errors", 64'(bad), 64'd0);
        check("t6_tlast_count", 64'(lasts), 64'd1);
        if (log_b.size() == FFT) check("t6_final_tl", 64'(log_b[FFT-1][32]), 64'd1);
        check("t6_st_never_cp", 64'(st1_seen), 64'd0);
        check("t6_frame_err",   64'(fe_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
